// File: rtl/imem_arbiter.sv
// imem_arbiter: two-requester round-robin arbiter in front of the single
// combinational read port of the instruction ROM.
//
// Port 0 is the processor fetch path, port 1 the debug/readback path. Each
// port has a valid/ready request handshake and a one-entry registered
// response slot that can be back-pressured. At most one ROM read is issued
// per cycle; the read data is captured into the granted port's slot on the
// same edge, giving a one-cycle request-to-response latency.
//
// Ports:
//   clk, reset             clock; synchronous active-low reset
//   req0_valid/addr/ready  port 0 request handshake (ready = grant)
//   rsp0_valid/data/ready  port 0 response slot
//   req1_* / rsp1_*        same for port 1
//   mem_addr               ROM address (0 when nothing is granted)
//   mem_q                  ROM read data, combinational in mem_addr
module imem_arbiter #(
  parameter int unsigned N = 32,
  parameter int unsigned A = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [A-1:0] req0_addr,
  output logic         req0_ready,
  output logic         rsp0_valid,
  output logic [N-1:0] rsp0_data,
  input  logic         rsp0_ready,
  input  logic         req1_valid,
  input  logic [A-1:0] req1_addr,
  output logic         req1_ready,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp1_data,
  input  logic         rsp1_ready,
  output logic [A-1:0] mem_addr,
  input  logic [N-1:0] mem_q
);

  logic eligible0, eligible1;
  logic grant0, grant1;

  // Port that won the most recent grant; the other port wins the next tie.
  logic last_grant_q, last_grant_d;

  logic         rsp0_valid_q, rsp0_valid_d;
  logic [N-1:0] rsp0_data_q, rsp0_data_d;
  logic         rsp1_valid_q, rsp1_valid_d;
  logic [N-1:0] rsp1_data_q, rsp1_data_d;

  // A full slot can only take a new request in the cycle it is drained, so
  // responses are never overwritten.
  always_comb begin
    eligible0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
    eligible1 = req1_valid && (!rsp1_valid_q || rsp1_ready);
  end

  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    mem_addr = '0;
    if (eligible0 && eligible1) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = eligible0;
      grant1 = eligible1;
    end
    if (grant0) begin
      mem_addr = req0_addr;
    end else if (grant1) begin
      mem_addr = req1_addr;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // A grant and a drain on the same port in one cycle reload the slot, so the
  // grant case takes priority and keeps valid high.
  always_comb begin
    last_grant_d = last_grant_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;

    if (grant0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = mem_q;
      last_grant_d = 1'b0;
    end else if (rsp0_valid_q && rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (grant1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = mem_q;
      last_grant_d = 1'b1;
    end else if (rsp1_valid_q && rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  // last_grant resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;

  // Structural invariants of the arbiter.
  a_one_grant : assert property (@(posedge clk) disable iff (!reset)
    !(req0_ready && req1_ready));

  a_idle_addr : assert property (@(posedge clk) disable iff (!reset)
    (!req0_ready && !req1_ready) |-> (mem_addr == '0));

  a_no_overwrite0 : assert property (@(posedge clk) disable iff (!reset)
    (rsp0_valid && !rsp0_ready) |-> !req0_ready);

  a_no_overwrite1 : assert property (@(posedge clk) disable iff (!reset)
    (rsp1_valid && !rsp1_ready) |-> !req1_ready);

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter. The stimulus process drives one
// directed vector per cycle, checks the combinational grant/address, and
// pushes the hand-computed response word for each grant. A monitor at the
// negedge pops and compares every freshly loaded response slot and checks
// that stalled slots hold their word.
module tb_imem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [5:0]  req0_addr, req1_addr, mem_addr;
  logic [31:0] rsp0_data, rsp1_data, mem_q;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  imem_arbiter #(.N(32), .A(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_ready (rsp0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_ready (rsp1_ready),
    .mem_addr   (mem_addr),
    .mem_q      (mem_q)
  );

  // ROM model: known program words at the addresses the vectors use.
  function automatic logic [31:0] rom_word(input logic [5:0] a);
    case (a)
      6'd0:    rom_word = 32'hf8000001;
      6'd1:    rom_word = 32'hf8008002;
      6'd2:    rom_word = 32'hf8000203;
      6'd3:    rom_word = 32'h8b050083;
      6'd23:   rom_word = 32'hf840000c;
      default: rom_word = {26'h0, a} | 32'h01000000;
    endcase
  endfunction

  assign mem_q = rom_word(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One stimulus cycle: drive, check grant/address, queue expected responses,
  // then advance to just after the next negedge.
  task automatic cyc(input logic rst,
                     input logic v0, input logic [5:0] a0, input logic r0,
                     input logic v1, input logic [5:0] a1, input logic r1,
                     input logic chk, input logic g0, input logic g1,
                     input logic [5:0] ea, input logic [31:0] d0, input logic [31:0] d1);
    reset      = rst;
    req0_valid = v0;
    req0_addr  = a0;
    rsp0_ready = r0;
    req1_valid = v1;
    req1_addr  = a1;
    rsp1_ready = r1;
    #1;
    if (chk) begin
      check("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
      check("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
      check("mem_addr", {26'b0, mem_addr}, {26'b0, ea});
    end
    if (rst && g0) q0.push_back(d0);
    if (rst && g1) q1.push_back(d1);
    @(negedge clk);
    #1;
  endtask

  // Monitor state, per port: valid seen at the previous negedge and the word
  // last expected in the slot.
  logic        prev_v[2];
  logic [31:0] last_exp[2];

  task automatic mon_port(input int i, input logic v, input logic r, input logic [31:0] d);
    logic        hs;
    logic [31:0] e;
    hs = prev_v[i] && r;
    if (v && (!prev_v[i] || hs)) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp%0d unexpected: got %h, required no response", i, d);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        check((i == 0) ? "rsp0_data" : "rsp1_data", d, e);
        last_exp[i] = e;
      end
    end else if (prev_v[i] && !hs) begin
      check((i == 0) ? "rsp0 stall valid" : "rsp1 stall valid", {31'b0, v}, 32'd1);
      check((i == 0) ? "rsp0 stall data" : "rsp1 stall data", d, last_exp[i]);
    end
    prev_v[i] = v;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
    end else begin
      mon_port(0, rsp0_valid, rsp0_ready, rsp0_data);
      mon_port(1, rsp1_valid, rsp1_ready, rsp1_data);
    end
  end

  initial begin
    prev_v[0]   = 1'b0;
    prev_v[1]   = 1'b0;
    last_exp[0] = '0;
    last_exp[1] = '0;

    // Reset held two cycles with both ports requesting.
    cyc(0, 1, 6'd5, 1, 1, 6'd7, 1, 0, 0, 0, 6'd0, 32'h0, 32'h0);
    cyc(0, 1, 6'd5, 1, 1, 6'd7, 1, 0, 0, 0, 6'd0, 32'h0, 32'h0);
    check("reset rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    check("reset rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    check("reset rsp0_data", rsp0_data, 32'h0);
    check("reset rsp1_data", rsp1_data, 32'h0);

    // Contention: port 0 wins first, then strict alternation.
    cyc(1, 1, 6'd3, 1, 1, 6'd23, 1, 1, 1, 0, 6'd3,  32'h8b050083, 32'h0);
    cyc(1, 1, 6'd3, 1, 1, 6'd23, 1, 1, 0, 1, 6'd23, 32'h0, 32'hf840000c);
    cyc(1, 1, 6'd3, 1, 1, 6'd23, 1, 1, 1, 0, 6'd3,  32'h8b050083, 32'h0);
    cyc(1, 1, 6'd3, 1, 1, 6'd23, 1, 1, 0, 1, 6'd23, 32'h0, 32'hf840000c);
    cyc(1, 0, 6'd0, 1, 0, 6'd0,  1, 1, 0, 0, 6'd0,  32'h0, 32'h0);

    // Port 0 streaming, one read per cycle.
    cyc(1, 1, 6'd0, 1, 0, 6'd0, 1, 1, 1, 0, 6'd0, 32'hf8000001, 32'h0);
    cyc(1, 1, 6'd1, 1, 0, 6'd0, 1, 1, 1, 0, 6'd1, 32'hf8008002, 32'h0);
    cyc(1, 1, 6'd2, 1, 0, 6'd0, 1, 1, 1, 0, 6'd2, 32'hf8000203, 32'h0);
    cyc(1, 1, 6'd3, 1, 0, 6'd0, 1, 1, 1, 0, 6'd3, 32'h8b050083, 32'h0);

    // Drain only: slot empties, data holds, no ROM address.
    cyc(1, 0, 6'd9, 1, 0, 6'd0, 1, 1, 0, 0, 6'd0, 32'h0, 32'h0);
    check("drain rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    check("drain rsp0_data", rsp0_data, 32'h8b050083);

    // Backpressure on port 1: held slot blocks the next request.
    cyc(1, 0, 6'd0, 1, 1, 6'd0, 0, 1, 0, 1, 6'd0, 32'h0, 32'hf8000001);
    cyc(1, 0, 6'd0, 1, 1, 6'd1, 0, 1, 0, 0, 6'd0, 32'h0, 32'h0);
    cyc(1, 0, 6'd0, 1, 1, 6'd1, 0, 1, 0, 0, 6'd0, 32'h0, 32'h0);
    cyc(1, 0, 6'd0, 1, 1, 6'd1, 0, 1, 0, 0, 6'd0, 32'h0, 32'h0);
    cyc(1, 0, 6'd0, 1, 1, 6'd1, 1, 1, 0, 1, 6'd1, 32'h0, 32'hf8008002);
    check("bp rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
    cyc(1, 0, 6'd0, 1, 0, 6'd0, 1, 1, 0, 0, 6'd0, 32'h0, 32'h0);

    // Load both slots, then reset mid-operation.
    cyc(1, 1, 6'd2, 0, 1, 6'd3, 0, 1, 1, 0, 6'd2, 32'hf8000203, 32'h0);
    cyc(1, 0, 6'd0, 0, 1, 6'd3, 0, 1, 0, 1, 6'd3, 32'h0, 32'h8b050083);
    cyc(0, 1, 6'd1, 0, 1, 6'd2, 0, 1, 0, 0, 6'd0, 32'h0, 32'h0);
    check("midreset rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    check("midreset rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    check("midreset rsp0_data", rsp0_data, 32'h0);
    check("midreset rsp1_data", rsp1_data, 32'h0);

    // First contention after reset goes to port 0 again.
    cyc(1, 1, 6'd1, 1, 1, 6'd2, 1, 1, 1, 0, 6'd1, 32'hf8008002, 32'h0);
    cyc(1, 0, 6'd0, 1, 1, 6'd2, 1, 1, 0, 1, 6'd2, 32'h0, 32'hf8000203);
    cyc(1, 0, 6'd0, 1, 0, 6'd0, 1, 1, 0, 0, 6'd0, 32'h0, 32'h0);
    cyc(1, 0, 6'd0, 1, 0, 6'd0, 1, 1, 0, 0, 6'd0, 32'h0, 32'h0);

    check("q0 leftover", q0.size(), 32'd0);
    check("q1 leftover", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
